// File: rtl/upc_scanner.sv
`default_nettype none
// ============================================================================
// Module      : upc_scanner
// Description : Serial barcode-head frame receiver. Samples sdata on clock
//               edges qualified by bit_en and decodes a 7-bit frame:
//               start(1), u, p, c, m, even parity, stop(0).
//               A good frame loads {u,p,c,m}, pulses valid and bumps a
//               saturating item counter; a bad frame pulses frame_err only.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-high reset
//               sdata      - serial scan data
//               bit_en     - sample strobe for sdata
//               u,p,c,m    - last accepted code (MSB..LSB), registered
//               valid      - one-cycle pulse, new code on u,p,c,m
//               frame_err  - one-cycle pulse, frame rejected
//               item_count - accepted frames, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module upc_scanner (
    input  logic       clk,
    input  logic       reset,
    input  logic       sdata,
    input  logic       bit_en,
    output logic       u,
    output logic       p,
    output logic       c,
    output logic       m,
    output logic       valid,
    output logic       frame_err,
    output logic [7:0] item_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [7:0] c_count_max = 8'hFF;

    state_t     r_state;
    logic [1:0] r_bit_cnt;
    logic [3:0] r_shift;
    logic       r_parity;
    logic [3:0] r_code;
    logic       r_valid;
    logic       r_frame_err;
    logic [7:0] r_count;

    // Frame is good when data plus parity have even weight and stop is low.
    logic w_frame_good;
    assign w_frame_good = ~(^r_shift ^ r_parity) & ~sdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 2'd0;
            r_shift     <= 4'd0;
            r_parity    <= 1'b0;
            r_code      <= 4'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            // Pulses last a single cycle unless re-armed below.
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    IDLE: begin
                        if (sdata) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 2'd0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {r_shift[2:0], sdata};
                        r_bit_cnt <= r_bit_cnt + 2'd1;
                        if (r_bit_cnt == 2'd3) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= sdata;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                        if (w_frame_good) begin
                            r_code  <= r_shift;
                            r_valid <= 1'b1;
                            if (r_count != c_count_max) begin
                                r_count <= r_count + 8'd1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign u          = r_code[3];
    assign p          = r_code[2];
    assign c          = r_code[1];
    assign m          = r_code[0];
    assign valid      = r_valid;
    assign frame_err  = r_frame_err;
    assign item_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_upc_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_upc_scanner
// Description : Self-checking bench for upc_scanner. Frames are issued by a
//               stimulus process that predicts each frame's outcome from the
//               frame rules and queues it; a negedge monitor pops and compares
//               whenever valid or frame_err is seen, and also tracks the held
//               code and counter every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upc_scanner;

    logic       clk;
    logic       reset;
    logic       sdata;
    logic       bit_en;
    logic       u, p, c, m;
    logic       valid;
    logic       frame_err;
    logic [7:0] item_count;

    upc_scanner dut (
        .clk        (clk),
        .reset      (reset),
        .sdata      (sdata),
        .bit_en     (bit_en),
        .u          (u),
        .p          (p),
        .c          (c),
        .m          (m),
        .valid      (valid),
        .frame_err  (frame_err),
        .item_count (item_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         good;
        logic [3:0] code;
        logic [7:0] count;
        int         cyc;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state seen by the stimulus side (updated when a frame is issued).
    logic [3:0] m_code  = 4'd0;
    int         m_count = 0;
    // Reference state seen by the monitor (updated when a pulse is observed).
    logic [3:0] exp_code = 4'd0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("reset_outputs", {20'd0, u, p, c, m, valid, frame_err, item_count}, 32'd0);
            exp_code = 4'd0;
            exp_cnt  = 8'd0;
        end else begin
            check("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (valid || frame_err) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse at cycle %0d: valid=%0d frame_err=%0d, expected none",
                             cyc, valid, frame_err);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind_valid", {31'd0, valid}, {31'd0, e.good});
                    check("pulse_latency", cyc, e.cyc);
                    if (e.good) begin
                        exp_code = e.code;
                        exp_cnt  = e.count;
                    end
                end
            end else if (q.size() > 0 && cyc >= q[0].cyc) begin
                e = q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse at cycle %0d: no valid/frame_err, expected one at cycle %0d",
                         cyc, e.cyc);
            end
            check("code_held", {28'd0, u, p, c, m}, {28'd0, exp_code});
            check("item_count", {24'd0, item_count}, {24'd0, exp_cnt});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b, input int gmin, input int gmax);
        int g;
        g = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
        repeat (g) begin
            @(posedge clk);
            #1;
            bit_en = 1'b0;
            sdata  = 1'($urandom % 2);
        end
        @(posedge clk);
        #1;
        bit_en = 1'b1;
        sdata  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bit_en = 1'b0;
            sdata  = 1'($urandom % 2);
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic perr, input logic serr,
                              input int gmin, input int gmax);
        logic [6:0] bits;
        logic       par;
        bit         good;
        exp_t       e;
        par  = (^d) ^ perr;
        bits = {1'b1, d, par, serr};
        for (int i = 6; i >= 0; i--) send_bit(bits[i], gmin, gmax);
        good = !perr && !serr;
        if (good) begin
            m_code = d;
            if (m_count < 255) m_count++;
        end
        e.good  = good;
        e.code  = m_code;
        e.count = 8'(m_count);
        e.cyc   = cyc + 1;
        q.push_back(e);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_reset_code", {28'd0, u, p, c, m}, 32'd0);
        check("async_reset_count", {24'd0, item_count}, 32'd0);
        check("async_reset_pulses", {30'd0, valid, frame_err}, 32'd0);
        m_code  = 4'd0;
        m_count = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic partial_then_reset(input int nbits);
        send_bit(1'b1, 0, 1);
        for (int i = 1; i < nbits; i++) send_bit(1'($urandom % 2), 0, 1);
        mid_reset();
    endtask

    initial begin
        reset  = 1'b1;
        bit_en = 1'b0;
        sdata  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed frames.
        send_frame(4'b1010, 1'b0, 1'b0, 0, 0);   // good, code 1010
        send_frame(4'b1010, 1'b1, 1'b0, 0, 0);   // parity error
        send_frame(4'b0111, 1'b0, 1'b1, 2, 2);   // stop error, strobe every 3rd cycle
        idle(3);

        // Idle noise: zeros with strobe must not start a frame.
        for (int i = 0; i < 20; i++) send_bit(1'b0, 0, 0);
        send_frame(4'b0011, 1'b0, 1'b0, 0, 1);

        // Saturation with back-to-back frames of code 0110.
        for (int i = 0; i < 257; i++) send_frame(4'b0110, 1'b0, 1'b0, 0, 0);
        idle(2);

        // Reset after the 2nd data bit, then a good frame of 1111.
        partial_then_reset(3);
        send_frame(4'b1111, 1'b0, 1'b0, 0, 0);
        idle(2);

        // Randomised frames, noise and mid-frame resets.
        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = int'($urandom % 20);
            if (sel == 0) begin
                partial_then_reset(int'($urandom_range(6, 1)));
            end else if (sel == 1) begin
                for (int i = 0; i < int'($urandom_range(5, 1)); i++) send_bit(1'b0, 0, 2);
            end else begin
                send_frame(4'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0, 0, 3);
            end
        end

        idle(5);
        check("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
